// File: rtl/avalon_sdram_responder_if.sv
// Avalon-MM bus between an SDRAM-side initiator (master) and the responder (slave).
// Active-low read/write strobes and byte enables.
interface avalon_sdram_responder_if #(
    parameter int unsigned ADDR_WIDTH = 24
);
    logic [ADDR_WIDTH-1:0] avalon_sdram_address;
    logic [1:0]            avalon_sdram_byteenable_n;
    logic                  avalon_sdram_chipselect;
    logic [15:0]           avalon_sdram_writedata;
    logic                  avalon_sdram_read_n;
    logic                  avalon_sdram_write_n;
    logic [15:0]           avalon_sdram_readdata;
    logic                  avalon_sdram_readdatavalid;
    logic                  avalon_sdram_waitrequest;

    modport master (
        output avalon_sdram_address, avalon_sdram_byteenable_n, avalon_sdram_chipselect,
        output avalon_sdram_writedata, avalon_sdram_read_n, avalon_sdram_write_n,
        input  avalon_sdram_readdata, avalon_sdram_readdatavalid, avalon_sdram_waitrequest
    );

    modport slave (
        input  avalon_sdram_address, avalon_sdram_byteenable_n, avalon_sdram_chipselect,
        input  avalon_sdram_writedata, avalon_sdram_read_n, avalon_sdram_write_n,
        output avalon_sdram_readdata, avalon_sdram_readdatavalid, avalon_sdram_waitrequest
    );
endinterface

// File: rtl/avalon_sdram_responder.sv
// SDRAM stand-in: Avalon-MM slave with wait states, refresh windows and fixed-latency reads.
// Optional RESP_ADDR_CHECK_EN: out-of-range accesses flag protocol_err and read back 16'hDEAD.
module avalon_sdram_responder #(
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned MEM_AW         = 8,
    parameter int unsigned RD_LATENCY     = 3,
    parameter int unsigned WAIT_CYCLES    = 1,
    parameter int unsigned REFRESH_PERIOD = 64,
    parameter int unsigned REFRESH_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    avalon_sdram_responder_if.slave bus,
    output logic                    protocol_err
);
    localparam int unsigned Depth     = 1 << MEM_AW;
    localparam int unsigned WcW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned RtW       = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam int unsigned RcW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam bit          RefreshEn = (REFRESH_PERIOD != 0) && (REFRESH_CYCLES != 0);
    localparam int unsigned RefLast   = (REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0;
    localparam int unsigned RcLast    = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;

    typedef enum logic [1:0] {StIdle, StWait, StRefresh} state_e;

    state_e                state_q;
    logic [WcW-1:0]        wait_cnt_q;
    logic [RtW-1:0]        ref_timer_q;
    logic [RcW-1:0]        ref_cnt_q;
    logic                  ref_pend_q;
    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [15:0]           pipe_dat_q [RD_LATENCY];
    logic [15:0]           rdata_q;
    logic                  rvalid_q;
    logic                  perr_q;
    logic [15:0]           mem_q [Depth];

    logic [ADDR_WIDTH-1:0] addr;
    logic [MEM_AW-1:0]     idx;
    logic                  oob;
    logic                  req, both, wait_req, accept;
    logic                  rd_ok, wr_ok;
    logic [15:0]           rd_word;
    logic                  wrap, due;

    assign addr = bus.avalon_sdram_address;
    assign idx  = addr[MEM_AW-1:0];
    assign oob  = (addr >> MEM_AW) != '0;
    assign req  = bus.avalon_sdram_chipselect &
                  (~bus.avalon_sdram_read_n | ~bus.avalon_sdram_write_n);
    assign both = ~bus.avalon_sdram_read_n & ~bus.avalon_sdram_write_n;

    always_comb begin
        wait_req = 1'b1;
        if (!req && state_q != StRefresh) begin
            wait_req = 1'b0;
        end else if (state_q != StRefresh && wait_cnt_q == WcW'(WAIT_CYCLES)) begin
            wait_req = 1'b0;
        end
    end

    assign accept = req & ~wait_req;
    // A simultaneous read+write performs only the write.
    assign rd_ok  = accept & ~bus.avalon_sdram_read_n & bus.avalon_sdram_write_n;

`ifdef RESP_ADDR_CHECK_EN
    assign wr_ok   = accept & ~bus.avalon_sdram_write_n & ~oob;
    assign rd_word = oob ? 16'hDEAD : mem_q[idx];
`else
    logic unused_oob;
    assign unused_oob = oob;
    assign wr_ok      = accept & ~bus.avalon_sdram_write_n;
    assign rd_word    = mem_q[idx];
`endif

    assign wrap = RefreshEn && (ref_timer_q == RtW'(RefLast));
    assign due  = wrap | ref_pend_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            ref_timer_q <= '0;
            ref_cnt_q   <= '0;
            ref_pend_q  <= 1'b0;
        end else begin
            if (RefreshEn) begin
                ref_timer_q <= wrap ? '0 : ref_timer_q + 1'b1;
            end
            // Remember a wrap that cannot be served yet; cleared on refresh entry below.
            if (wrap) begin
                ref_pend_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (due) begin
                        state_q    <= StRefresh;
                        ref_cnt_q  <= '0;
                        ref_pend_q <= 1'b0;
                        wait_cnt_q <= '0;
                    end else if (req && (WAIT_CYCLES != 0)) begin
                        state_q    <= StWait;
                        wait_cnt_q <= WcW'(1);
                    end
                end
                StWait: begin
                    if (accept) begin
                        wait_cnt_q <= '0;
                        if (due) begin
                            state_q    <= StRefresh;
                            ref_cnt_q  <= '0;
                            ref_pend_q <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (!req) begin
                        wait_cnt_q <= '0;
                        state_q    <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StRefresh: begin
                    if (ref_cnt_q == RcW'(RcLast)) begin
                        state_q    <= StIdle;
                        wait_cnt_q <= '0;
                    end else begin
                        ref_cnt_q <= ref_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            pipe_vld_q[0] <= rd_ok;
            pipe_dat_q[0] <= rd_word;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_dat_q[i] <= pipe_dat_q[i-1];
            end
            rvalid_q <= pipe_vld_q[RD_LATENCY-1];
            if (pipe_vld_q[RD_LATENCY-1]) begin
                rdata_q <= pipe_dat_q[RD_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            if (accept && both) begin
                perr_q <= 1'b1;
            end
`ifdef RESP_ADDR_CHECK_EN
            if (accept && oob) begin
                perr_q <= 1'b1;
            end
`endif
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            if (!bus.avalon_sdram_byteenable_n[0]) begin
                mem_q[idx][7:0] <= bus.avalon_sdram_writedata[7:0];
            end
            if (!bus.avalon_sdram_byteenable_n[1]) begin
                mem_q[idx][15:8] <= bus.avalon_sdram_writedata[15:8];
            end
        end
    end

    assign bus.avalon_sdram_readdata      = rdata_q;
    assign bus.avalon_sdram_readdatavalid = rvalid_q;
    assign bus.avalon_sdram_waitrequest   = wait_req;
    assign protocol_err                   = perr_q;
endmodule

// File: tb/tb_avalon_sdram_responder.sv
// Scoreboard bench: two responders (wait-state build and refresh build) driven by one master.
module tb_avalon_sdram_responder;
    localparam int unsigned AW  = 24;
    localparam int unsigned LAT = 3;
`ifdef RESP_ADDR_CHECK_EN
    localparam bit AddrChk = 1'b1;
`else
    localparam bit AddrChk = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_sdram_responder_if #(.ADDR_WIDTH(AW)) bus_a ();
    avalon_sdram_responder_if #(.ADDR_WIDTH(AW)) bus_b ();
    logic perr_a, perr_b;

    avalon_sdram_responder #(
        .ADDR_WIDTH(AW), .MEM_AW(8), .RD_LATENCY(LAT), .WAIT_CYCLES(1),
        .REFRESH_PERIOD(0), .REFRESH_CYCLES(4)
    ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a), .protocol_err(perr_a));

    avalon_sdram_responder #(
        .ADDR_WIDTH(AW), .MEM_AW(8), .RD_LATENCY(LAT), .WAIT_CYCLES(0),
        .REFRESH_PERIOD(16), .REFRESH_CYCLES(4)
    ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b), .protocol_err(perr_b));

    int          sel;
    logic [AW-1:0] s_addr;
    logic [1:0]  s_be;
    logic        s_cs;
    logic [15:0] s_wd;
    logic        s_rd_n, s_wr_n;
    logic        wait_sel;

    assign bus_a.avalon_sdram_address      = s_addr;
    assign bus_a.avalon_sdram_byteenable_n = s_be;
    assign bus_a.avalon_sdram_chipselect   = s_cs & (sel == 0);
    assign bus_a.avalon_sdram_writedata    = s_wd;
    assign bus_a.avalon_sdram_read_n       = s_rd_n;
    assign bus_a.avalon_sdram_write_n      = s_wr_n;
    assign bus_b.avalon_sdram_address      = s_addr;
    assign bus_b.avalon_sdram_byteenable_n = s_be;
    assign bus_b.avalon_sdram_chipselect   = s_cs & (sel == 1);
    assign bus_b.avalon_sdram_writedata    = s_wd;
    assign bus_b.avalon_sdram_read_n       = s_rd_n;
    assign bus_b.avalon_sdram_write_n      = s_wr_n;
    assign wait_sel = (sel == 1) ? bus_b.avalon_sdram_waitrequest
                                 : bus_a.avalon_sdram_waitrequest;

    // Reference model: word memory per responder, sticky error, expected read returns.
    logic [15:0] mdl [2][256];
    bit          perr_m [2];
    logic [15:0] last_rd [2];
    exp_t        q0[$];
    exp_t        q1[$];
    int          errors = 0;
    int          checks = 0;

    bit          rec = 1'b0;
    bit          wr_hist[$];
    always @(negedge clk) if (rec) wr_hist.push_back(bus_b.avalon_sdram_waitrequest);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input int w, input logic [AW-1:0] addr, input logic [1:0] be,
                                input logic [15:0] wd, input bit rd, input bit wr);
        int   idx;
        bit   oob;
        exp_t e;
        idx = int'(addr % 256);
        oob = addr >= 256;
        if (AddrChk && oob) perr_m[w] = 1'b1;
        if (wr && !(AddrChk && oob)) begin
            if (!be[0]) mdl[w][idx][7:0] = wd[7:0];
            if (!be[1]) mdl[w][idx][15:8] = wd[15:8];
        end
        if (rd && wr) begin
            perr_m[w] = 1'b1;
        end else if (rd) begin
            e.d   = (AddrChk && oob) ? 16'hDEAD : mdl[w][idx];
            e.due = cyc + int'(LAT);
            if (w == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic xfer(input int w, input logic [AW-1:0] addr, input logic [1:0] be,
                        input logic [15:0] wd, input bit rd, input bit wr, output int stalls);
        bit acc;
        sel = w; s_addr = addr; s_be = be; s_wd = wd;
        s_rd_n = !rd; s_wr_n = !wr; s_cs = 1'b1;
        stalls = 0;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (wait_sel === 1'b0) acc = 1'b1; else stalls++;
            @(posedge clk);
            #1;
        end
        s_cs = 1'b0; s_rd_n = 1'b1; s_wr_n = 1'b1;
        if (acc) begin
            model_accept(w, addr, be, wd, rd, wr);
        end else begin
            checks++; errors++;
            $display("FAIL accept_timeout%0d: got no accept in 50 cycles expected accept", w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon(input int w, input logic v, input logic [15:0] d, input logic pe);
        exp_t h;
        bit   have;
        h = '0;
        if (rst_n !== 1'b1) begin
            if (w == 0) q0.delete(); else q1.delete();
            perr_m[w]  = 1'b0;
            last_rd[w] = 16'h0;
            return;
        end
        have = (w == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) h = (w == 0) ? q0[0] : q1[0];
        chk($sformatf("protocol_err%0d", w), 32'(pe), 32'(perr_m[w]));
        if (v === 1'b1) begin
            if (!have) begin
                checks++; errors++;
                $display("FAIL spurious_valid%0d: got valid data 0x%0h expected none", w, d);
            end else begin
                if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                chk($sformatf("rd_data%0d", w), 32'(d), 32'(h.d));
                chk($sformatf("rd_latency%0d", w), cyc, h.due);
            end
            last_rd[w] = d;
        end else begin
            chk($sformatf("rd_hold%0d", w), 32'(d), 32'(last_rd[w]));
            if (have && h.due <= cyc) begin
                checks++; errors++;
                $display("FAIL missed_valid%0d: got no valid expected 0x%0h", w, h.d);
                if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.avalon_sdram_readdatavalid, bus_a.avalon_sdram_readdata, perr_a);
        mon(1, bus_b.avalon_sdram_readdatavalid, bus_b.avalon_sdram_readdata, perr_b);
    end

    task automatic analyze_refresh();
        int starts[$];
        int lens[$];
        int i, j;
        i = 1;
        while (i < wr_hist.size()) begin
            if (wr_hist[i] && !wr_hist[i-1]) begin
                j = i;
                while (j < wr_hist.size() && wr_hist[j]) j++;
                if (j < wr_hist.size()) begin
                    starts.push_back(i);
                    lens.push_back(j - i);
                end
                i = j;
            end else begin
                i++;
            end
        end
        chk("refresh_windows_seen", 32'(starts.size() >= 3), 32'd1);
        foreach (lens[k]) chk("refresh_len", lens[k], 4);
        for (int k = 1; k < starts.size(); k++) chk("refresh_spacing", starts[k] - starts[k-1], 16);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int st, vc;
        rst_n = 1'b0; sel = 0; s_cs = 1'b0; s_rd_n = 1'b1; s_wr_n = 1'b1;
        s_addr = '0; s_be = 2'b00; s_wd = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rdata_a", 32'(bus_a.avalon_sdram_readdata), 32'h0);
        chk("reset_valid_a", 32'(bus_a.avalon_sdram_readdatavalid), 32'h0);
        chk("reset_perr_a", 32'(perr_a), 32'h0);
        chk("reset_rdata_b", 32'(bus_b.avalon_sdram_readdata), 32'h0);
        chk("reset_valid_b", 32'(bus_b.avalon_sdram_readdatavalid), 32'h0);
        chk("reset_perr_b", 32'(perr_b), 32'h0);
        @(posedge clk);
        #1;

        // Single wait state on write and read; latency checked by the monitor.
        xfer(0, 24'd2, 2'b00, 16'h1234, 1'b0, 1'b1, st);
        chk("wait_stall_write", st, 1);
        xfer(0, 24'd2, 2'b00, 16'h0000, 1'b1, 1'b0, st);
        chk("wait_stall_read", st, 1);
        idle(6);

        // Byte lanes.
        xfer(0, 24'd5, 2'b00, 16'h0000, 1'b0, 1'b1, st);
        xfer(0, 24'd5, 2'b10, 16'hABCD, 1'b0, 1'b1, st);
        chk("lane_model", 32'(mdl[0][5]), 32'h00CD);
        xfer(0, 24'd5, 2'b00, 16'h0000, 1'b1, 1'b0, st);
        xfer(0, 24'd5, 2'b11, 16'hFFFF, 1'b0, 1'b1, st);
        xfer(0, 24'd5, 2'b00, 16'h0000, 1'b1, 1'b0, st);
        idle(6);

        // Zero-wait back-to-back reads.
        for (int i = 0; i < 4; i++) xfer(1, AW'(i), 2'b00, 16'h1111 * 16'(i + 1), 1'b0, 1'b1, st);
        for (int i = 0; i < 4; i++) xfer(1, AW'(i), 2'b00, 16'h0, 1'b1, 1'b0, st);
        idle(6);

        // Continuous writes through refresh windows.
        rec = 1'b1;
        for (int i = 0; i < 80; i++) xfer(1, AW'(8 + i % 8), 2'b00, 16'($urandom), 1'b0, 1'b1, st);
        rec = 1'b0;
        analyze_refresh();
        for (int i = 8; i < 16; i++) xfer(1, AW'(i), 2'b00, 16'h0, 1'b1, 1'b0, st);
        idle(8);

        // Reset one cycle after a read accept.
        xfer(0, 24'd2, 2'b00, 16'h0, 1'b1, 1'b0, st);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        vc = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus_a.avalon_sdram_readdatavalid === 1'b1) vc++;
        end
        chk("reset_drops_reads", vc, 0);
        chk("reset_perr_clear", 32'(perr_a), 32'h0);
        @(posedge clk);
        #1;

        // Simultaneous read+write: write wins, error is sticky.
        xfer(0, 24'd7, 2'b00, 16'h5A5A, 1'b1, 1'b1, st);
        @(negedge clk);
        chk("rw_conflict_perr", 32'(perr_a), 32'h1);
        @(posedge clk);
        #1;
        xfer(0, 24'd7, 2'b00, 16'h0, 1'b1, 1'b0, st);
`ifdef RESP_ADDR_CHECK_EN
        xfer(1, 24'h000100, 2'b00, 16'h0, 1'b1, 1'b0, st);
        idle(5);
        chk("oob_perr", 32'(perr_b), 32'h1);
`endif
        idle(6);

        // Randomised traffic on both responders.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) xfer(w, AW'(i), 2'b00, 16'($urandom), 1'b0, 1'b1, st);
            for (int i = 0; i < 150; i++) begin
                int unsigned op, lo, hi;
                logic [AW-1:0] a;
                op = $urandom_range(0, 15);
                lo = $urandom_range(0, 15);
                hi = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
                a  = AW'(lo) | (AW'(hi) << 8);
                xfer(w, a, 2'($urandom), 16'($urandom), op < 7 || op == 15, op >= 7, st);
                idle($urandom_range(0, 2));
            end
        end

        idle(10);
        chk("drain_a", q0.size(), 0);
        chk("drain_b", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
